// File: rtl/multiply_map_seq_if.sv
// rtl/multiply_map_seq_if.sv - command, flag, EV store port and status bundle for multiply_map_seq
// slave is the sequencer side; master is the dispatch/store side.
interface multiply_map_seq_if #(
  parameter int DEPTH     = 256,
  parameter int AW        = $clog2(DEPTH),
  parameter int NUM_FLAGS = 8,
  parameter int FSW       = $clog2(NUM_FLAGS)
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [AW-1:0]        cmd_origin;
  logic [AW-1:0]        cmd_modifier;
  logic [AW:0]          cmd_length;
  logic                 cmd_cond_en;
  logic [FSW-1:0]       cmd_cond_sel;
  logic [NUM_FLAGS-1:0] flags;
  logic                 rd_a_en;
  logic [AW-1:0]        rd_a_addr;
  logic [31:0]          rd_a_data;
  logic                 rd_b_en;
  logic [AW-1:0]        rd_b_addr;
  logic [31:0]          rd_b_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [31:0]          wr_data;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 skipped;

  modport slave (
    input  cmd_valid, cmd_origin, cmd_modifier, cmd_length, cmd_cond_en, cmd_cond_sel,
    input  flags, rd_a_data, rd_b_data,
    output cmd_ready, rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    output wr_en, wr_addr, wr_data, busy, done, err, skipped
  );

  modport master (
    output cmd_valid, cmd_origin, cmd_modifier, cmd_length, cmd_cond_en, cmd_cond_sel,
    output flags, rd_a_data, rd_b_data,
    input  cmd_ready, rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    input  wr_en, wr_addr, wr_data, busy, done, err, skipped
  );
endinterface

// File: rtl/multiply_map_seq.sv
// rtl/multiply_map_seq.sv - one-element-per-two-cycles multiply-map sequencer over the EV word store
// MULTIPLY_MAP_OVERLAP_ORDER_EN: iterate descending when modifier < origin < modifier+length instead of rejecting.
module multiply_map_seq #(
  parameter int DEPTH     = 256,
  parameter int AW        = $clog2(DEPTH),
  parameter int NUM_FLAGS = 8,
  parameter int FSW       = $clog2(NUM_FLAGS)
) (
  input  logic              clk,
  input  logic              rst,
  multiply_map_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, FIN} state_t;

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

`ifdef MULTIPLY_MAP_OVERLAP_ORDER_EN
  localparam bit REVERSE_OK = 1'b1;
`else
  localparam bit REVERSE_OK = 1'b0;
`endif

  state_t               state, state_nxt;
  logic [AW-1:0]        origin_q, modifier_q, idx_q, idx_nxt;
  logic [AW:0]          length_q;
  logic                 cond_pass_q;
  logic                 desc_q, desc_nxt;
  logic                 err_q, err_nxt, skip_q, skip_nxt;
  logic [AW+1:0]        org_end, mod_end;
  logic                 out_of_range, overlap_rev, last_elem, accept;
  logic [31:0]          prod;
  logic [NUM_FLAGS-1:0] flags_w;
  logic [FSW-1:0]       sel_w;

  assign flags_w = bus.flags;
  assign sel_w   = bus.cmd_cond_sel;
  assign accept  = bus.cmd_valid && (state == IDLE);

  assign org_end      = {2'b00, origin_q}   + {1'b0, length_q};
  assign mod_end      = {2'b00, modifier_q} + {1'b0, length_q};
  assign out_of_range = (org_end > DEPTH_W) || (mod_end > DEPTH_W);
  // Ascending order would overwrite an operand before it is read only in this window.
  assign overlap_rev  = (modifier_q < origin_q) && ({2'b00, origin_q} < mod_end);
  assign last_elem    = desc_q ? (idx_q == '0)
                               : ({1'b0, idx_q} == (length_q - (AW+1)'(1)));
  assign prod         = bus.rd_a_data * bus.rd_b_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      origin_q    <= '0;
      modifier_q  <= '0;
      length_q    <= '0;
      cond_pass_q <= 1'b0;
      idx_q       <= '0;
      desc_q      <= 1'b0;
      err_q       <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      desc_q <= desc_nxt;
      err_q  <= err_nxt;
      skip_q <= skip_nxt;
      if (accept) begin
        origin_q    <= bus.cmd_origin;
        modifier_q  <= bus.cmd_modifier;
        length_q    <= bus.cmd_length;
        cond_pass_q <= !bus.cmd_cond_en || flags_w[sel_w];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    desc_nxt  = desc_q;
    err_nxt   = err_q;
    skip_nxt  = skip_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CHECK;
          err_nxt   = 1'b0;
          skip_nxt  = 1'b0;
          desc_nxt  = 1'b0;
        end
      end
      CHECK: begin
        if (out_of_range || (overlap_rev && !REVERSE_OK)) begin
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else if (!cond_pass_q) begin
          skip_nxt  = 1'b1;
          state_nxt = FIN;
        end else if (length_q == '0) begin
          state_nxt = FIN;
        end else begin
          desc_nxt  = overlap_rev;
          idx_nxt   = overlap_rev ? (length_q[AW-1:0] - AW'(1)) : '0;
          state_nxt = RD;
        end
      end
      RD: state_nxt = WR;
      WR: begin
        if (last_elem) begin
          state_nxt = FIN;
        end else begin
          idx_nxt   = desc_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));
          state_nxt = RD;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are masked by rst so an aborting reset edge never commits a store write.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rd_a_en   = (state == RD) && !rst;
  assign bus.rd_b_en   = (state == RD) && !rst;
  assign bus.rd_a_addr = (state == RD) ? (origin_q + idx_q) : '0;
  assign bus.rd_b_addr = (state == RD) ? (modifier_q + idx_q) : '0;
  assign bus.wr_en     = (state == WR) && !rst;
  assign bus.wr_addr   = (state == WR) ? (origin_q + idx_q) : '0;
  assign bus.wr_data   = (state == WR) ? prod : '0;
  assign bus.done      = (state == FIN) && !rst;
  assign bus.err       = (state == FIN) && err_q;
  assign bus.skipped   = (state == FIN) && skip_q;

endmodule
